// File: rtl/dna_digit_packer.sv
// Packs N 2-bit nucleotide digits into a 2N-bit word, with one word of buffering behind the output register.
// Optional build macro DNA_PACKER_COMPLEMENT_EN stores every accepted digit complemented (d -> 3-d).
module dna_digit_packer #(
    parameter int N       = 4,
    parameter bit REVERSE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [1:0]                 in_digit,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [2*N-1:0]             word_out,
    input  logic                       out_ready,
    output logic [$clog2(N+1)-1:0]     digit_cnt
);

    localparam int              CW   = $clog2(N + 1);
    localparam int              W    = 2 * N;
    localparam logic [CW-1:0]   FULL = CW'(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    logic [W-1:0]  coll_q, coll_d;
    logic [W-1:0]  word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;

    logic [W-1:0]  filled;
    logic [CW-1:0] slot;
    logic [1:0]    digit_s;
    logic          slot_free;
    logic          accept;

    // in_ready depends only on state, so out_ready never reaches it combinationally.
    assign in_ready  = (cnt_q != FULL);
    assign slot_free = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign word_out  = word_q;
    assign digit_cnt = cnt_q;

    always_comb begin
`ifdef DNA_PACKER_COMPLEMENT_EN
        digit_s = ~in_digit;
`else
        digit_s = in_digit;
`endif
        slot   = REVERSE ? cnt_q : (LAST - cnt_q);
        filled = coll_q;
        for (int k = 0; k < N; k++) begin
            if (slot == CW'(k)) filled[2*k +: 2] = digit_s;
        end
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        coll_d      = coll_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (cnt_q == FULL) begin
            // Waiting word moves up as soon as the output register frees; no digit is taken this cycle.
            if (slot_free) begin
                word_d      = coll_q;
                out_valid_d = 1'b1;
                cnt_d       = '0;
            end
        end else if (accept) begin
            if (cnt_q == LAST) begin
                if (slot_free) begin
                    word_d      = filled;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    coll_d = filled;
                    cnt_d  = FULL;
                end
            end else begin
                coll_d = filled;
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q      <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            coll_q      <= coll_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_dna_digit_packer.sv
// Self-checking bench for dna_digit_packer: REVERSE=1 and REVERSE=0 instances share one stimulus stream.
// Expected values come from a queue-based model of digits and pending words.
module tb_dna_digit_packer;

    localparam int N  = 4;
    localparam int W  = 2 * N;
    localparam int CW = $clog2(N + 1);

`ifdef DNA_PACKER_COMPLEMENT_EN
    localparam logic [W-1:0] EXP_1002_R = 8'h7E;
    localparam logic [W-1:0] EXP_1002_F = 8'hBD;
    localparam logic [W-1:0] EXP_2013_F = 8'h78;
    localparam logic [W-1:0] EXP_2013_R = 8'h2D;
    localparam logic [W-1:0] EXP_3122_R = 8'h58;
`else
    localparam logic [W-1:0] EXP_1002_R = 8'h81;
    localparam logic [W-1:0] EXP_1002_F = 8'h42;
    localparam logic [W-1:0] EXP_2013_F = 8'h87;
    localparam logic [W-1:0] EXP_2013_R = 8'hD2;
    localparam logic [W-1:0] EXP_3122_R = 8'hA7;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [1:0]    in_digit;
    logic          out_ready;
    logic          ir_r, ov_r, ir_f, ov_f;
    logic [W-1:0]  wo_r, wo_f;
    logic [CW-1:0] cnt_r, cnt_f;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dna_digit_packer #(.N(N), .REVERSE(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_digit(in_digit),
        .in_ready(ir_r), .out_valid(ov_r), .word_out(wo_r), .out_ready(out_ready),
        .digit_cnt(cnt_r)
    );

    dna_digit_packer #(.N(N), .REVERSE(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_digit(in_digit),
        .in_ready(ir_f), .out_valid(ov_f), .word_out(wo_f), .out_ready(out_ready),
        .digit_cnt(cnt_f)
    );

    // Reference model: digits of the word being collected, and completed words not yet consumed
    // (front = output register, second entry = word waiting in the collector).
    int            part[$];
    logic [W-1:0]  pend_r[$];
    logic [W-1:0]  pend_f[$];
    logic [W-1:0]  last_r, last_f;

    function automatic int stored(input logic [1:0] d);
`ifdef DNA_PACKER_COMPLEMENT_EN
        return 3 - int'(d);
`else
        return int'(d);
`endif
    endfunction

    function automatic logic [W-1:0] build(input bit rev);
        longint acc = 0;
        for (int k = 0; k < N; k++)
            acc += longint'(part[k]) * (longint'(1) << (2 * (rev ? k : N - 1 - k)));
        return W'(acc);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        part.delete();
        pend_r.delete();
        pend_f.delete();
        last_r = '0;
        last_f = '0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] d, input logic r);
        bit full = (pend_r.size() == 2);
        if (pend_r.size() > 0 && r) begin
            last_r = pend_r.pop_front();
            last_f = pend_f.pop_front();
        end
        if (v && !full) begin
            part.push_back(stored(d));
            if (part.size() == N) begin
                pend_r.push_back(build(1'b1));
                pend_f.push_back(build(1'b0));
                part.delete();
            end
        end
    endtask

    task automatic check_state(input string tag);
        logic [W-1:0] exp_wr, exp_wf;
        logic [CW-1:0] exp_cnt;
        exp_wr  = (pend_r.size() > 0) ? pend_r[0] : last_r;
        exp_wf  = (pend_f.size() > 0) ? pend_f[0] : last_f;
        exp_cnt = (pend_r.size() == 2) ? CW'(N) : CW'(part.size());
        chk({tag, " in_ready_r"},  W'(ir_r),  W'(pend_r.size() < 2));
        chk({tag, " out_valid_r"}, W'(ov_r),  W'(pend_r.size() > 0));
        chk({tag, " word_out_r"},  wo_r,      exp_wr);
        chk({tag, " digit_cnt_r"}, W'(cnt_r), W'(exp_cnt));
        chk({tag, " in_ready_f"},  W'(ir_f),  W'(pend_f.size() < 2));
        chk({tag, " out_valid_f"}, W'(ov_f),  W'(pend_f.size() > 0));
        chk({tag, " word_out_f"},  wo_f,      exp_wf);
        chk({tag, " digit_cnt_f"}, W'(cnt_f), W'(exp_cnt));
    endtask

    // Check current outputs, drive one cycle of inputs, advance the model across the edge.
    task automatic step(input string tag, input logic v, input logic [1:0] d, input logic r);
        check_state(tag);
        in_valid  = v;
        in_digit  = d;
        out_ready = r;
        @(posedge clk);
        model_edge(v, d, r);
        #1;
    endtask

    initial begin
        int pulses;
        int last_pulse;
        bit ir_always;
        logic [1:0] seq_a[4];
        logic [1:0] seq_b[4];
        logic [1:0] seq_c[4];
        seq_a = '{2'd1, 2'd0, 2'd0, 2'd2};
        seq_b = '{2'd2, 2'd0, 2'd1, 2'd3};
        seq_c = '{2'd3, 2'd1, 2'd2, 2'd2};

        rst_n = 1'b0; in_valid = 1'b0; in_digit = 2'd0; out_ready = 1'b0;
        model_reset();
        #12;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // REVERSE=1 / REVERSE=0 packing of 1,0,0,2 with out_ready high.
        for (int i = 0; i < 4; i++) step("pack_a", 1'b1, seq_a[i], 1'b1);
        check_state("pack_a_done");
        chk("rev_word_1002", wo_r, EXP_1002_R);
        chk("fwd_word_1002", wo_f, EXP_1002_F);
        chk("rev_valid_1002", W'(ov_r), W'(1));
        step("drain_a", 1'b0, 2'd0, 1'b1);
        chk("rev_valid_clear", W'(ov_r), W'(0));
        chk("word_retained", wo_r, EXP_1002_R);

        for (int i = 0; i < 4; i++) step("pack_b", 1'b1, seq_b[i], 1'b1);
        chk("fwd_word_2013", wo_f, EXP_2013_F);
        chk("rev_word_2013", wo_r, EXP_2013_R);
        for (int i = 0; i < 4; i++) step("pack_c", 1'b1, seq_c[i], 1'b1);
        chk("rev_word_3122", wo_r, EXP_3122_R);
        step("drain_c", 1'b0, 2'd0, 1'b1);

        // Backpressure: two words, first held in output, second in collector.
        for (int i = 0; i < 4; i++) step("bp_a", 1'b1, seq_a[i], 1'b0);
        for (int i = 0; i < 4; i++) step("bp_b", 1'b1, seq_b[i], 1'b0);
        chk("bp_held_word", wo_r, EXP_1002_R);
        chk("bp_cnt_full", W'(cnt_r), W'(N));
        chk("bp_in_ready_low", W'(ir_r), W'(0));
        step("bp_ninth", 1'b1, 2'd3, 1'b0);
        chk("bp_ninth_rejected", W'(cnt_r), W'(N));
        step("bp_release", 1'b0, 2'd0, 1'b1);
        chk("bp_second_word", wo_r, EXP_2013_R);
        chk("bp_cnt_zero", W'(cnt_r), W'(0));
        chk("bp_in_ready_back", W'(ir_r), W'(1));
        chk("bp_valid_kept", W'(ov_r), W'(1));
        step("bp_drain", 1'b0, 2'd0, 1'b1);

        // Streaming: 12 back-to-back digits, pulses every 4 cycles.
        pulses = 0; last_pulse = -1; ir_always = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!ir_r) ir_always = 1'b0;
            step("stream", 1'b1, 2'($urandom_range(0, 3)), 1'b1);
            if (ov_r) begin
                if (last_pulse >= 0) chk("stream_gap", W'(i - last_pulse), W'(4));
                last_pulse = i;
                pulses++;
            end
        end
        chk("stream_pulses", W'(pulses), W'(3));
        chk("stream_in_ready", W'(ir_always), W'(1));
        step("stream_end", 1'b0, 2'd0, 1'b1);

        // Asynchronous reset mid-word.
        step("rst_pre", 1'b1, 2'd3, 1'b1);
        step("rst_pre", 1'b1, 2'd2, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_cnt", W'(cnt_r), W'(0));
        chk("rst_async_valid", W'(ov_r), W'(0));
        chk("rst_async_word", wo_r, W'(0));
        model_reset();
        check_state("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("post_rst", 1'b1, seq_a[i], 1'b1);
        chk("post_rst_word", wo_r, EXP_1002_R);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step("random", 1'(($urandom % 4) != 0), 2'($urandom_range(0, 3)),
                 1'(($urandom % 3) != 0));
        check_state("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dna_digit_packer.md
# dna_digit_packer

Serial-to-parallel assembler for DNA words. It accepts one 2-bit nucleotide digit per cycle over a valid/ready handshake and packs N digits into a 2N-bit word. By default it packs first-received-digit-last, so the packed result is the reversed word. It sits on the receive side of the word-reversal datapath and presents completed words to downstream word-level logic through a second valid/ready handshake, with one word of buffering.

## Interface

- N, default 4: digits per word. Legal range is N ≥ 2.
- REVERSE, default 1: placement order. 1 places the first digit at word_out[1:0]. 0 places the first digit at word_out[2N-1:2N-2].

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: in_digit is valid.
- in_digit, input, 2: nucleotide digit (0..3).
- in_ready, output, 1: packer accepts a digit this cycle.
- out_valid, output, 1: word_out holds a complete word.
- word_out, output, 2N: packed word.
- out_ready, input, 1: downstream consumes word_out this cycle.
- digit_cnt, output, ⌈log2(N+1)⌉: digits held in the collector (0..N).

## Operation

- The block has two storage stages.
  - **Collector:** 2N-bit shift register plus digit_cnt.
  - **Output register:** word_out plus out_valid.
- A digit is accepted when in_valid && in_ready. It is written into collector slot digit_cnt, and digit_cnt increments.
  - REVERSE=1: slot k maps to bits [2k+1:2k].
  - REVERSE=0: slot k maps to bits [2(N-1-k)+1:2(N-1-k)].
- The output slot is free when !out_valid || out_ready.
- When the N-th digit is accepted and the output slot is free:
  - the completed word loads directly into word_out;
  - out_valid is set;
  - digit_cnt returns to 0.
- When the N-th digit is accepted and the output slot is not free:
  - digit_cnt becomes N (collector full);
  - in_ready = 0.
- Collector full and output slot becomes free:
  - the collector word transfers to word_out;
  - out_valid stays or becomes 1;
  - digit_cnt becomes 0.
  - No digit is accepted in that cycle.
- in_ready = (digit_cnt != N). It is purely a function of state, with no combinational path from out_ready.
- out_valid && out_ready with no new word arriving: out_valid clears next cycle. word_out retains its last value.
- word_out is stable while out_valid && !out_ready.
- Unaccepted in_digit values have no effect. in_digit outside an accepted cycle is don't-care.
- Reset (rst_n low, any time, including mid-word or mid-transfer):
  - partial and pending words are discarded;
  - digit_cnt = 0, in_ready = 1, out_valid = 0, word_out = 0, collector = 0.

## Timing

- Latency: N-th digit accepted on edge t → out_valid = 1 and word_out valid immediately after edge t.
- Throughput: one digit per cycle sustained when out_ready is held high. No bubbles between words.
- Backpressure:
  - One complete word can wait in the collector behind the word in the output register.
  - in_ready deasserts the cycle after the N-th digit of that second word is accepted.
  - in_ready reasserts the cycle after the transfer edge.
- Reset assertion takes effect asynchronously. Deassertion is synchronous to clk in the system.
- The first acceptance can occur on the first rising edge with rst_n high.

## Configuration

- Macro: DNA_PACKER_COMPLEMENT_EN.
- Defined: each accepted digit is stored complemented (d → 3-d, i.e. bitwise NOT: A↔T, C↔G). The packer then emits the reverse complement when REVERSE=1.
- Undefined: digits are stored unmodified.
- Handshake, timing and reset behaviour are identical in both builds.

## Test plan

- **REVERSE=1 packing:** N=4, REVERSE=1, out_ready=1, digits 1,0,0,2 on consecutive cycles → word_out = 8'b10_00_00_01 with out_valid=1 one cycle after the 4th acceptance, then out_valid=0.
- **REVERSE=0 packing:** N=4, REVERSE=0, digits 2,0,1,3 → word_out = 8'b10_00_01_11.
- **Complement build:** DNA_PACKER_COMPLEMENT_EN defined, N=4, REVERSE=1, digits 3,1,2,2 → word_out = 8'b01_01_10_00.
- **Backpressure:** out_ready=0, stream 8 digits (1,0,0,2,2,0,1,3) → first word 8'b10_00_00_01 is held and digit_cnt reaches 4. in_ready=0 after the 8th digit, and a 9th in_valid is not accepted. Raise out_ready for one cycle → word_out becomes 8'b11_01_00_10, digit_cnt=0, and in_ready=1 the next cycle.
- **Streaming:** out_ready=1, 12 back-to-back digits → three out_valid pulses exactly 4 cycles apart, with in_ready constantly 1.
- **Reset mid-operation:**
  - Accept 2 digits, pulse rst_n low mid-cycle → outputs go immediately to digit_cnt=0, out_valid=0, word_out=0.
  - Then send 1,0,0,2 → word_out = 8'b10_00_00_01, with no stale digits.
